// File: rtl/lsu_wb_if.sv
// Load/store unit bus bundle: execute-stage request, data-memory req/ack handshake
// and the register-file write port driven by the LSU.
interface lsu_wb_if;
    localparam int unsigned DW = 32;
    localparam int unsigned OW = 6;
    localparam int unsigned AW = 5;

    logic          Start;
    logic [OW-1:0] Opcode;
    logic [DW-1:0] Addr;
    logic [DW-1:0] Sdata;
    logic [AW-1:0] Rt;
    logic          Mreq;
    logic          Mwe;
    logic [DW-1:0] Maddr;
    logic [DW-1:0] Mwdata;
    logic [DW-1:0] Mrdata;
    logic          Mack;
    logic          Busy;
    logic          Wen;
    logic [AW-1:0] Wadr;
    logic [DW-1:0] Wdata;
    logic          Err;

    modport master (
        input  Start, Opcode, Addr, Sdata, Rt, Mrdata, Mack,
        output Mreq, Mwe, Maddr, Mwdata, Busy, Wen, Wadr, Wdata, Err
    );

    modport slave (
        output Start, Opcode, Addr, Sdata, Rt, Mrdata, Mack,
        input  Mreq, Mwe, Maddr, Mwdata, Busy, Wen, Wadr, Wdata, Err
    );
endinterface

// File: rtl/lsu_wb.sv
// Load/store unit: runs LW/SW accesses over a req/ack data-memory handshake with a
// timeout, and drives the register-file write port for completed loads.
module lsu_wb #(
    parameter int unsigned TIMEOUT = 16,
    parameter logic [5:0]  LW_OP   = 6'b100011,
    parameter logic [5:0]  SW_OP   = 6'b101011
) (
    input  logic     CLK,
    input  logic     RST_N,
    lsu_wb_if.master bus
);
    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned CNT_W = 8;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_ACCESS = 2'd1,
        S_WB     = 2'd2
    } state_e;

    state_e           r_state, w_state_nxt;
    logic             r_mreq, w_mreq_nxt;
    logic             r_mwe, w_mwe_nxt;
    logic [DW-1:0]    r_maddr, w_maddr_nxt;
    logic [DW-1:0]    r_mwdata, w_mwdata_nxt;
    logic             r_busy, w_busy_nxt;
    logic             r_wen, w_wen_nxt;
    logic [AW-1:0]    r_wadr, w_wadr_nxt;
    logic [DW-1:0]    r_wdata, w_wdata_nxt;
    logic             r_err, w_err_nxt;
    logic [AW-1:0]    r_rt, w_rt_nxt;
    logic [CNT_W-1:0] r_cnt, w_cnt_nxt;
    logic             w_op_ok;
    logic             w_aligned;

    assign w_op_ok   = (bus.Opcode == LW_OP) || (bus.Opcode == SW_OP);
    assign w_aligned = (bus.Addr[1:0] == 2'b00);

    // Next-state and next-output logic; r_mwe doubles as the latched op (0 = LW).
    always_comb begin
        w_state_nxt  = r_state;
        w_mreq_nxt   = r_mreq;
        w_mwe_nxt    = r_mwe;
        w_maddr_nxt  = r_maddr;
        w_mwdata_nxt = r_mwdata;
        w_busy_nxt   = r_busy;
        w_wen_nxt    = 1'b0;
        w_wadr_nxt   = r_wadr;
        w_wdata_nxt  = r_wdata;
        w_err_nxt    = 1'b0;
        w_rt_nxt     = r_rt;
        w_cnt_nxt    = r_cnt;

        unique case (r_state)
            S_IDLE: begin
                if (bus.Start && w_op_ok) begin
                    if (w_aligned) begin
                        w_state_nxt  = S_ACCESS;
                        w_mreq_nxt   = 1'b1;
                        w_mwe_nxt    = (bus.Opcode == SW_OP);
                        w_busy_nxt   = 1'b1;
                        w_cnt_nxt    = '0;
                        w_maddr_nxt  = {2'b00, bus.Addr[DW-1:2]};
                        w_mwdata_nxt = bus.Sdata;
                        w_rt_nxt     = bus.Rt;
                    end else begin
                        w_err_nxt = 1'b1;
                    end
                end
            end

            S_ACCESS: begin
                // An acknowledge takes priority over an expiring timeout.
                if (bus.Mack) begin
                    w_mreq_nxt = 1'b0;
                    w_busy_nxt = 1'b0;
                    if (r_mwe) begin
                        w_state_nxt = S_IDLE;
                    end else begin
                        w_state_nxt = S_WB;
                        w_wen_nxt   = 1'b1;
                        w_wadr_nxt  = r_rt;
                        w_wdata_nxt = bus.Mrdata;
                    end
                end else if (r_cnt == CNT_LAST) begin
                    w_state_nxt = S_IDLE;
                    w_mreq_nxt  = 1'b0;
                    w_busy_nxt  = 1'b0;
                    w_err_nxt   = 1'b1;
                end else begin
                    w_cnt_nxt = r_cnt + CNT_W'(1);
                end
            end

            S_WB: begin
                w_state_nxt = S_IDLE;
            end

            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state  <= S_IDLE;
            r_mreq   <= 1'b0;
            r_mwe    <= 1'b0;
            r_maddr  <= '0;
            r_mwdata <= '0;
            r_busy   <= 1'b0;
            r_wen    <= 1'b0;
            r_wadr   <= '0;
            r_wdata  <= '0;
            r_err    <= 1'b0;
            r_rt     <= '0;
            r_cnt    <= '0;
        end else begin
            r_state  <= w_state_nxt;
            r_mreq   <= w_mreq_nxt;
            r_mwe    <= w_mwe_nxt;
            r_maddr  <= w_maddr_nxt;
            r_mwdata <= w_mwdata_nxt;
            r_busy   <= w_busy_nxt;
            r_wen    <= w_wen_nxt;
            r_wadr   <= w_wadr_nxt;
            r_wdata  <= w_wdata_nxt;
            r_err    <= w_err_nxt;
            r_rt     <= w_rt_nxt;
            r_cnt    <= w_cnt_nxt;
        end
    end

    assign bus.Mreq   = r_mreq;
    assign bus.Mwe    = r_mwe;
    assign bus.Maddr  = r_maddr;
    assign bus.Mwdata = r_mwdata;
    assign bus.Busy   = r_busy;
    assign bus.Wen    = r_wen;
    assign bus.Wadr   = r_wadr;
    assign bus.Wdata  = r_wdata;
    assign bus.Err    = r_err;
endmodule

// File: tb/tb_lsu_wb.sv
// Self-checking bench for lsu_wb: directed scenarios plus randomized LW/SW traffic
// checked against a transaction-level model with its own word memory.
module tb_lsu_wb;
    localparam int unsigned TMO   = 16;
    localparam logic [5:0]  LW    = 6'b100011;
    localparam logic [5:0]  SW    = 6'b101011;
    localparam logic [5:0]  ADDI  = 6'b001000;
    localparam int          NEVER = 1000;

    logic clk;
    logic rst_n;
    lsu_wb_if bus ();

    lsu_wb #(.TIMEOUT(TMO), .LW_OP(LW), .SW_OP(SW)) dut (
        .CLK   (clk),
        .RST_N (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Observations gathered by run_txn for one transaction window.
    int          obs_mreq_cyc, obs_mreq_first, obs_wen_cnt, obs_wen_cyc;
    int          obs_err_cnt, obs_err_cyc, obs_busy_cyc, obs_unstable;
    logic        obs_mwe, obs_busy_at_wen;
    logic [31:0] obs_maddr, obs_mwdata, obs_wdata;
    logic [4:0]  obs_wadr;

    logic [31:0] phys_mem  [16];
    logic [31:0] model_mem [16];

    // Drive one request in cycle 0, then act as memory for 40 cycles and record outputs.
    task automatic run_txn(input logic [5:0] op, input logic [31:0] addr, input logic [31:0] sdata,
                           input logic [4:0] rt, input int wait_n, input int inject_c,
                           input logic [5:0] inj_op, input logic [31:0] inj_addr, input bit spurious);
        obs_mreq_cyc = 0; obs_mreq_first = 0; obs_wen_cnt = 0; obs_wen_cyc = 0;
        obs_err_cnt = 0; obs_err_cyc = 0; obs_busy_cyc = 0; obs_unstable = 0;
        obs_mwe = 1'b0; obs_busy_at_wen = 1'b0; obs_maddr = '0; obs_mwdata = '0;
        obs_wdata = '0; obs_wadr = '0;
        @(posedge clk); #1;
        bus.Start = 1'b1; bus.Opcode = op; bus.Addr = addr; bus.Sdata = sdata; bus.Rt = rt;
        bus.Mack = 1'b0;
        for (int c = 1; c <= 40; c++) begin
            @(posedge clk); #1;
            bus.Start = (c == inject_c);
            if (c == inject_c) begin
                bus.Opcode = inj_op; bus.Addr = inj_addr; bus.Sdata = $urandom;
            end
            bus.Mack = 1'b0; bus.Mrdata = $urandom;
            if (bus.Busy) obs_busy_cyc++;
            if (bus.Err) begin obs_err_cnt++; obs_err_cyc = c; end
            if (bus.Wen) begin
                obs_wen_cnt++; obs_wen_cyc = c; obs_wadr = bus.Wadr; obs_wdata = bus.Wdata;
                obs_busy_at_wen = bus.Busy;
            end
            if (bus.Mreq) begin
                obs_mreq_cyc++;
                if (obs_mreq_cyc == 1) begin
                    obs_mreq_first = c; obs_maddr = bus.Maddr; obs_mwe = bus.Mwe;
                    obs_mwdata = bus.Mwdata;
                end else if (bus.Maddr !== obs_maddr || bus.Mwe !== obs_mwe ||
                             bus.Mwdata !== obs_mwdata) begin
                    obs_unstable++;
                end
                if (obs_mreq_cyc == wait_n + 1) begin
                    bus.Mack = 1'b1;
                    bus.Mrdata = phys_mem[bus.Maddr[3:0]];
                    if (bus.Mwe) phys_mem[bus.Maddr[3:0]] = bus.Mwdata;
                end
            end else if (spurious && $urandom_range(0, 3) == 0) begin
                bus.Mack = 1'b1;
            end
        end
        bus.Mack = 1'b0; bus.Start = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        @(posedge clk); #2;
        n_checks++; if (bus.Mreq !== 1'b0) $display("FAIL reset_mreq got %b want 0", bus.Mreq); else n_pass++;
        n_checks++; if (bus.Mwe !== 1'b0) $display("FAIL reset_mwe got %b want 0", bus.Mwe); else n_pass++;
        n_checks++; if (bus.Busy !== 1'b0) $display("FAIL reset_busy got %b want 0", bus.Busy); else n_pass++;
        n_checks++; if (bus.Wen !== 1'b0) $display("FAIL reset_wen got %b want 0", bus.Wen); else n_pass++;
        n_checks++; if (bus.Err !== 1'b0) $display("FAIL reset_err got %b want 0", bus.Err); else n_pass++;
        n_checks++; if (bus.Maddr !== 32'h0) $display("FAIL reset_maddr got %h want 0", bus.Maddr); else n_pass++;
        n_checks++; if (bus.Mwdata !== 32'h0) $display("FAIL reset_mwdata got %h want 0", bus.Mwdata); else n_pass++;
        n_checks++; if (bus.Wadr !== 5'h0) $display("FAIL reset_wadr got %h want 0", bus.Wadr); else n_pass++;
        n_checks++; if (bus.Wdata !== 32'h0) $display("FAIL reset_wdata got %h want 0", bus.Wdata); else n_pass++;
        rst_n = 1'b1;
    endtask

    task automatic test_lw_basic();
        phys_mem[4] = 32'hDEAD_BEEF;
        run_txn(LW, 32'h0000_0010, 32'h0, 5'd8, 0, 0, 6'h0, 32'h0, 1'b0);
        n_checks++; if (obs_mreq_first !== 1) $display("FAIL lw_mreq_latency got %0d want 1", obs_mreq_first); else n_pass++;
        n_checks++; if (obs_mreq_cyc !== 1) $display("FAIL lw_mreq_cycles got %0d want 1", obs_mreq_cyc); else n_pass++;
        n_checks++; if (obs_maddr !== 32'h4) $display("FAIL lw_maddr got %h want 4", obs_maddr); else n_pass++;
        n_checks++; if (obs_mwe !== 1'b0) $display("FAIL lw_mwe got %b want 0", obs_mwe); else n_pass++;
        n_checks++; if (obs_wen_cnt !== 1 || obs_wen_cyc !== 2) $display("FAIL lw_wen got count %0d cycle %0d want 1 at 2", obs_wen_cnt, obs_wen_cyc); else n_pass++;
        n_checks++; if (obs_wadr !== 5'd8) $display("FAIL lw_wadr got %0d want 8", obs_wadr); else n_pass++;
        n_checks++; if (obs_wdata !== 32'hDEAD_BEEF) $display("FAIL lw_wdata got %h want deadbeef", obs_wdata); else n_pass++;
        n_checks++; if (obs_busy_at_wen !== 1'b0 || obs_busy_cyc !== 1) $display("FAIL lw_busy got at_wen %b cycles %0d want 0 and 1", obs_busy_at_wen, obs_busy_cyc); else n_pass++;
        n_checks++; if (bus.Wadr !== 5'd8 || bus.Wdata !== 32'hDEAD_BEEF) $display("FAIL lw_hold got %0d/%h want 8/deadbeef", bus.Wadr, bus.Wdata); else n_pass++;
    endtask

    task automatic test_sw_wait();
        run_txn(SW, 32'h0000_0020, 32'h1234_5678, 5'd3, 3, 0, 6'h0, 32'h0, 1'b0);
        n_checks++; if (obs_mreq_cyc !== 4) $display("FAIL sw_mreq_cycles got %0d want 4", obs_mreq_cyc); else n_pass++;
        n_checks++; if (obs_mwe !== 1'b1) $display("FAIL sw_mwe got %b want 1", obs_mwe); else n_pass++;
        n_checks++; if (obs_maddr !== 32'h8) $display("FAIL sw_maddr got %h want 8", obs_maddr); else n_pass++;
        n_checks++; if (obs_mwdata !== 32'h1234_5678) $display("FAIL sw_mwdata got %h want 12345678", obs_mwdata); else n_pass++;
        n_checks++; if (obs_unstable !== 0) $display("FAIL sw_stable got %0d changes want 0", obs_unstable); else n_pass++;
        n_checks++; if (obs_wen_cnt !== 0) $display("FAIL sw_no_wen got %0d want 0", obs_wen_cnt); else n_pass++;
        n_checks++; if (obs_busy_cyc !== 4) $display("FAIL sw_busy_cycles got %0d want 4", obs_busy_cyc); else n_pass++;
    endtask

    task automatic test_misaligned();
        run_txn(LW, 32'h0000_0013, 32'h0, 5'd9, 0, 0, 6'h0, 32'h0, 1'b0);
        n_checks++; if (obs_err_cnt !== 1 || obs_err_cyc !== 1) $display("FAIL mis_err got count %0d cycle %0d want 1 at 1", obs_err_cnt, obs_err_cyc); else n_pass++;
        n_checks++; if (obs_mreq_cyc !== 0) $display("FAIL mis_mreq got %0d want 0", obs_mreq_cyc); else n_pass++;
        n_checks++; if (obs_wen_cnt !== 0 || obs_busy_cyc !== 0) $display("FAIL mis_quiet got wen %0d busy %0d want 0/0", obs_wen_cnt, obs_busy_cyc); else n_pass++;
    endtask

    task automatic test_timeout();
        run_txn(LW, 32'h0000_0040, 32'h0, 5'd7, NEVER, 0, 6'h0, 32'h0, 1'b0);
        n_checks++; if (obs_mreq_cyc !== TMO) $display("FAIL tmo_mreq_cycles got %0d want %0d", obs_mreq_cyc, TMO); else n_pass++;
        n_checks++; if (obs_err_cnt !== 1 || obs_err_cyc !== TMO + 1) $display("FAIL tmo_err got count %0d cycle %0d want 1 at %0d", obs_err_cnt, obs_err_cyc, TMO + 1); else n_pass++;
        n_checks++; if (obs_busy_cyc !== TMO) $display("FAIL tmo_busy got %0d want %0d", obs_busy_cyc, TMO); else n_pass++;
        n_checks++; if (obs_wen_cnt !== 0) $display("FAIL tmo_no_wen got %0d want 0", obs_wen_cnt); else n_pass++;
    endtask

    task automatic test_reset_mid();
        @(posedge clk); #1;
        bus.Start = 1'b1; bus.Opcode = LW; bus.Addr = 32'h0000_002C; bus.Rt = 5'd5; bus.Mack = 1'b0;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        @(posedge clk); #1;
        n_checks++; if (bus.Mreq !== 1'b1) $display("FAIL rst_mid_pre got mreq %b want 1", bus.Mreq); else n_pass++;
        #2 rst_n = 1'b0;
        #1;
        n_checks++; if (bus.Mreq !== 1'b0 || bus.Busy !== 1'b0) $display("FAIL rst_mid_drop got mreq %b busy %b want 0/0", bus.Mreq, bus.Busy); else n_pass++;
        @(posedge clk); #3 rst_n = 1'b1;
        @(posedge clk); #1;
        n_checks++; if (bus.Wen !== 1'b0 || bus.Mreq !== 1'b0) $display("FAIL rst_mid_discard got wen %b mreq %b want 0/0", bus.Wen, bus.Mreq); else n_pass++;
        phys_mem[11] = 32'h0BAD_F00D;
        run_txn(LW, 32'h0000_002C, 32'h0, 5'd5, 1, 0, 6'h0, 32'h0, 1'b0);
        n_checks++; if (obs_wen_cnt !== 1 || obs_wen_cyc !== 3) $display("FAIL rst_mid_after_wen got count %0d cycle %0d want 1 at 3", obs_wen_cnt, obs_wen_cyc); else n_pass++;
        n_checks++; if (obs_wdata !== 32'h0BAD_F00D || obs_wadr !== 5'd5) $display("FAIL rst_mid_after_data got %0d/%h want 5/0badf00d", obs_wadr, obs_wdata); else n_pass++;
    endtask

    task automatic test_ignored();
        run_txn(ADDI, 32'h0000_0010, 32'h5555_5555, 5'd4, 0, 0, 6'h0, 32'h0, 1'b0);
        n_checks++; if (obs_mreq_cyc !== 0 || obs_err_cnt !== 0) $display("FAIL addi_ignored got mreq %0d err %0d want 0/0", obs_mreq_cyc, obs_err_cnt); else n_pass++;
        n_checks++; if (obs_wen_cnt !== 0 || obs_busy_cyc !== 0) $display("FAIL addi_quiet got wen %0d busy %0d want 0/0", obs_wen_cnt, obs_busy_cyc); else n_pass++;
        phys_mem[7] = 32'hCAFE_F00D;
        run_txn(LW, 32'h0000_001C, 32'h0, 5'd3, 3, 2, SW, 32'h0000_0030, 1'b0);
        n_checks++; if (obs_mreq_cyc !== 4 || obs_unstable !== 0) $display("FAIL busy_start_mreq got %0d cycles %0d changes want 4/0", obs_mreq_cyc, obs_unstable); else n_pass++;
        n_checks++; if (obs_maddr !== 32'h7 || obs_mwe !== 1'b0) $display("FAIL busy_start_addr got %h/%b want 7/0", obs_maddr, obs_mwe); else n_pass++;
        n_checks++; if (obs_wen_cnt !== 1 || obs_wdata !== 32'hCAFE_F00D || obs_wadr !== 5'd3) $display("FAIL busy_start_wb got %0d %0d/%h want 1 3/cafef00d", obs_wen_cnt, obs_wadr, obs_wdata); else n_pass++;
    endtask

    task automatic test_back_to_back();
        phys_mem[2] = 32'hA5A5_0001;
        @(posedge clk); #1;
        bus.Start = 1'b1; bus.Opcode = LW; bus.Addr = 32'h0000_0008; bus.Rt = 5'd0; bus.Mack = 1'b0;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        n_checks++; if (bus.Mreq !== 1'b1) $display("FAIL b2b_mreq1 got %b want 1", bus.Mreq); else n_pass++;
        bus.Mack = 1'b1; bus.Mrdata = phys_mem[2];
        @(posedge clk); #1;
        bus.Mack = 1'b0;
        n_checks++; if (bus.Wen !== 1'b1 || bus.Wadr !== 5'd0 || bus.Wdata !== 32'hA5A5_0001 || bus.Busy !== 1'b0) $display("FAIL b2b_r0_write got wen %b %0d/%h busy %b want 1 0/a5a50001 0", bus.Wen, bus.Wadr, bus.Wdata, bus.Busy); else n_pass++;
        @(posedge clk); #1;
        bus.Start = 1'b1; bus.Opcode = SW; bus.Addr = 32'h0000_0024; bus.Sdata = 32'h7777_0002;
        @(posedge clk); #1;
        bus.Start = 1'b0;
        n_checks++; if (bus.Mreq !== 1'b1 || bus.Mwe !== 1'b1 || bus.Maddr !== 32'h9 || bus.Busy !== 1'b1) $display("FAIL b2b_second got mreq %b mwe %b maddr %h busy %b want 1 1 9 1", bus.Mreq, bus.Mwe, bus.Maddr, bus.Busy); else n_pass++;
        bus.Mack = 1'b1;
        @(posedge clk); #1;
        bus.Mack = 1'b0;
        n_checks++; if (bus.Mreq !== 1'b0 || bus.Busy !== 1'b0 || bus.Wen !== 1'b0) $display("FAIL b2b_sw_done got mreq %b busy %b wen %b want 0 0 0", bus.Mreq, bus.Busy, bus.Wen); else n_pass++;
    endtask

    // Random LW/SW/other traffic against a transaction-level model with its own memory image.
    task automatic test_random();
        logic [5:0]  op;
        logic [31:0] addr, sdata, exp_wdata;
        logic [4:0]  rt;
        int          wait_n, exp_mreq, exp_err;
        bit          valid, aligned, go, acked, is_lw, exp_wen;
        for (int i = 0; i < 16; i++) begin
            phys_mem[i] = $urandom;
            model_mem[i] = phys_mem[i];
        end
        for (int t = 0; t < 40; t++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3, 4: op = LW;
                5, 6, 7, 8:    op = SW;
                default:       op = 6'($urandom);
            endcase
            addr = {26'd0, 4'($urandom_range(0, 15)), 2'b00};
            if ($urandom_range(0, 4) == 0) addr[1:0] = 2'($urandom_range(1, 3));
            sdata  = $urandom;
            rt     = 5'($urandom);
            wait_n = ($urandom_range(0, 9) == 0) ? 17 + int'($urandom_range(0, 3)) : int'($urandom_range(0, 4));

            valid     = (op == LW) || (op == SW);
            aligned   = (addr[1:0] == 2'b00);
            go        = valid && aligned;
            acked     = go && (wait_n < int'(TMO));
            is_lw     = (op == LW);
            exp_mreq  = !go ? 0 : (acked ? wait_n + 1 : int'(TMO));
            exp_err   = ((valid && !aligned) || (go && !acked)) ? 1 : 0;
            exp_wen   = acked && is_lw;
            exp_wdata = model_mem[addr[5:2]];
            if (acked && !is_lw) model_mem[addr[5:2]] = sdata;

            run_txn(op, addr, sdata, rt, wait_n, 0, 6'h0, 32'h0, 1'b1);
            n_checks++; if (obs_mreq_cyc !== exp_mreq || obs_busy_cyc !== exp_mreq) $display("FAIL rnd%0d_mreq got mreq %0d busy %0d want %0d", t, obs_mreq_cyc, obs_busy_cyc, exp_mreq); else n_pass++;
            n_checks++; if (obs_err_cnt !== exp_err) $display("FAIL rnd%0d_err got %0d want %0d", t, obs_err_cnt, exp_err); else n_pass++;
            n_checks++; if (obs_wen_cnt !== int'(exp_wen)) $display("FAIL rnd%0d_wen got %0d want %0d", t, obs_wen_cnt, exp_wen); else n_pass++;
            n_checks++; if (obs_unstable !== 0) $display("FAIL rnd%0d_stable got %0d changes want 0", t, obs_unstable); else n_pass++;
            if (go) begin
                n_checks++; if (obs_maddr !== {2'b00, addr[31:2]} || obs_mwe !== !is_lw) $display("FAIL rnd%0d_req got %h/%b want %h/%b", t, obs_maddr, obs_mwe, {2'b00, addr[31:2]}, !is_lw); else n_pass++;
                if (!is_lw) begin
                    n_checks++; if (obs_mwdata !== sdata) $display("FAIL rnd%0d_mwdata got %h want %h", t, obs_mwdata, sdata); else n_pass++;
                end
            end
            if (exp_wen) begin
                n_checks++; if (obs_wadr !== rt || obs_wdata !== exp_wdata || obs_wen_cyc !== wait_n + 2) $display("FAIL rnd%0d_wb got %0d/%h at %0d want %0d/%h at %0d", t, obs_wadr, obs_wdata, obs_wen_cyc, rt, exp_wdata, wait_n + 2); else n_pass++;
            end
        end
    endtask

    initial begin
        rst_n = 1'b0;
        bus.Start = 1'b0; bus.Opcode = '0; bus.Addr = '0; bus.Sdata = '0; bus.Rt = '0;
        bus.Mrdata = '0; bus.Mack = 1'b0;
        for (int i = 0; i < 16; i++) begin
            phys_mem[i] = '0;
            model_mem[i] = '0;
        end
        test_reset();
        test_lw_basic();
        test_sw_wait();
        test_misaligned();
        test_timeout();
        test_reset_mid();
        test_ignored();
        test_back_to_back();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
